img_win_read: RTL and testbench

//  Read-side counter/addresser for the input image memory: once the image has been

---
 rtl/img_pkg.sv | 24 ++
 rtl/img_rd_lat_pipe.sv | 38 +++
 rtl/img_win_read.sv | 144 ++++++++++++++
 tb/tb_img_win_read.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared constants and types for the image window read path.
// Image geometry, state encoding and counter types used by the addresser and its read pipe.
package img_pkg;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int K      = 3;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int KK     = K * K;
    localparam int TAP_W  = $clog2(KK);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PRESENT,
        DONE
    } rd_state_t;

    typedef logic [TAP_W-1:0] tap_t;
    typedef logic [7:0]       coord_t;

endpackage

// File: rtl/img_rd_lat_pipe.sv
// Delay line that carries {valid, tap index} alongside the image RAM read latency,
// so returning data lands in the window slot of the tap that requested it.
module img_rd_lat_pipe
    import img_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_valid,
    input  tap_t in_tap,
    output logic out_valid,
    output tap_t out_tap
);

    logic [DEPTH-1:0] vld_q;
    tap_t             tap_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                tap_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            tap_q[0] <= in_tap;
            for (int s = 1; s < DEPTH; s++) begin
                vld_q[s] <= vld_q[s-1];
                tap_q[s] <= tap_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_tap   = tap_q[DEPTH-1];

endmodule

// File: rtl/img_win_read.sv
// Walks every KxK window of the stored image, fetching one tap per cycle from the
// image RAM and presenting each completed window to the conv stage via valid/ready.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing K*K tap reads, one per cycle
// WAIT    | draining reads still in flight
// PRESENT | window complete, win_valid high until accepted
// DONE    | one-cycle done pulse after the last window
module img_win_read
    import img_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [DATA_W-1:0]      rd_data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [KK*DATA_W-1:0]   win_pixels,
    output logic [7:0]             win_row,
    output logic [7:0]             win_col,
    output logic                   busy,
    output logic                   done
);

    rd_state_t            state_q, state_d;
    tap_t                 tap_cnt;
    coord_t               tap_i, tap_j;
    coord_t               row_q, col_q;
    logic                 cap_valid;
    tap_t                 cap_tap;
    logic [KK*DATA_W-1:0] pix_q;
    logic                 last_tap, last_cap, accept, last_win;
    logic [ADDR_W-1:0]    addr_row, addr_col;

    assign last_tap = (tap_cnt == tap_t'(KK-1));
    assign last_cap = cap_valid && (cap_tap == tap_t'(KK-1));
    assign accept   = (state_q == PRESENT) && win_ready;
    assign last_win = (row_q == coord_t'(IMG_H-K)) && (col_q == coord_t'(IMG_W-K));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)     state_d = FETCH;
            FETCH:   if (last_tap)  state_d = WAIT;
            WAIT:    if (last_cap)  state_d = PRESENT;
            PRESENT: if (win_ready) state_d = last_win ? DONE : FETCH;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Tap walk (t, i, j) plus window origin; origin clears at start and after the last window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_cnt <= '0;
            tap_i   <= '0;
            tap_j   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                tap_cnt <= '0;
                tap_i   <= '0;
                tap_j   <= '0;
                row_q   <= '0;
                col_q   <= '0;
            end
            if (state_q == FETCH) begin
                if (last_tap) begin
                    tap_cnt <= '0;
                    tap_i   <= '0;
                    tap_j   <= '0;
                end else begin
                    tap_cnt <= tap_cnt + tap_t'(1);
                    if (tap_j == coord_t'(K-1)) begin
                        tap_j <= '0;
                        tap_i <= tap_i + coord_t'(1);
                    end else begin
                        tap_j <= tap_j + coord_t'(1);
                    end
                end
            end
            if (accept) begin
                if (last_win) begin
                    row_q <= '0;
                    col_q <= '0;
                end else if (col_q == coord_t'(IMG_W-K)) begin
                    col_q <= '0;
                    row_q <= row_q + coord_t'(1);
                end else begin
                    col_q <= col_q + coord_t'(1);
                end
            end
        end
    end

    img_rd_lat_pipe #(
        .DEPTH(RD_LAT)
    ) u_lat_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (rd_en),
        .in_tap   (tap_cnt),
        .out_valid(cap_valid),
        .out_tap  (cap_tap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q <= '0;
        end else if (cap_valid) begin
            for (int t = 0; t < KK; t++) begin
                if (cap_tap == tap_t'(t)) begin
                    pix_q[t*DATA_W +: DATA_W] <= rd_data;
                end
            end
        end
    end

    assign addr_row   = ADDR_W'(row_q) + ADDR_W'(tap_i);
    assign addr_col   = ADDR_W'(col_q) + ADDR_W'(tap_j);
    assign rd_en      = (state_q == FETCH);
    assign rd_addr    = rd_en ? (addr_row * ADDR_W'(IMG_W) + addr_col) : '0;
    assign win_valid  = (state_q == PRESENT);
    assign win_pixels = pix_q;
    assign win_row    = row_q;
    assign win_col    = col_q;
    assign busy       = (state_q == FETCH) || (state_q == WAIT) || (state_q == PRESENT);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_img_win_read.sv
// Scoreboard bench for img_win_read: RD_LAT=1 and RD_LAT=3 instances, RAM[a]=a[7:0],
// expected windows queued at start and popped by a monitor on every handshake.
module tb_img_win_read;

    typedef struct {
        logic [7:0]  row;
        logic [7:0]  col;
        logic [71:0] pix;
    } win_t;

    localparam logic [71:0] FIRST_PIX = {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0};
    localparam logic [71:0] LAST_PIX  = {8'd15, 8'd14, 8'd13, 8'd243, 8'd242, 8'd241, 8'd215, 8'd214, 8'd213};

    logic clk = 1'b0;
    logic reset_n;
    logic st, rdy, sel;

    logic        start1, ready1, rd_en1, win_valid1, busy1, done1;
    logic [9:0]  rd_addr1;
    logic [7:0]  rd_data1, row1, col1;
    logic [71:0] pix1;
    logic        start3, ready3, rd_en3, win_valid3, busy3, done3;
    logic [9:0]  rd_addr3;
    logic [7:0]  rd_data3, row3, col3;
    logic [71:0] pix3;
    logic [7:0]  r3a, r3b;

    logic        m_rd_en, m_valid, m_busy, m_done;
    logic [9:0]  m_rd_addr;
    logic [7:0]  m_row, m_col;
    logic [71:0] m_pix;

    int   tests = 0;
    int   fails = 0;
    win_t sb[$];

    always #5 clk = ~clk;

    assign start1 = st & ~sel;
    assign ready1 = rdy & ~sel;
    assign start3 = st & sel;
    assign ready3 = rdy & sel;

    img_win_read #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .win_valid(win_valid1), .win_ready(ready1), .win_pixels(pix1),
        .win_row(row1), .win_col(col1), .busy(busy1), .done(done1)
    );

    img_win_read #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .rd_en(rd_en3), .rd_addr(rd_addr3),
        .rd_data(rd_data3), .win_valid(win_valid3), .win_ready(ready3), .win_pixels(pix3),
        .win_row(row3), .win_col(col3), .busy(busy3), .done(done3)
    );

    // RAM model: data = low address byte; junk 0xEE when no read was issued
    always @(posedge clk) begin
        rd_data1 <= rd_en1 ? rd_addr1[7:0] : 8'hEE;
        r3a      <= rd_en3 ? rd_addr3[7:0] : 8'hEE;
        r3b      <= r3a;
        rd_data3 <= r3b;
    end

    assign m_rd_en   = sel ? rd_en3     : rd_en1;
    assign m_rd_addr = sel ? rd_addr3   : rd_addr1;
    assign m_valid   = sel ? win_valid3 : win_valid1;
    assign m_pix     = sel ? pix3       : pix1;
    assign m_row     = sel ? row3       : row1;
    assign m_col     = sel ? col3       : col1;
    assign m_busy    = sel ? busy3      : busy1;
    assign m_done    = sel ? done3      : done1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_all();
        win_t w;
        for (int r = 0; r <= 25; r++) begin
            for (int c = 0; c <= 25; c++) begin
                w.row = 8'(r);
                w.col = 8'(c);
                w.pix = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        w.pix[(i*3+j)*8 +: 8] = 8'((r + i) * 28 + (c + j));
                    end
                end
                sb.push_back(w);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && m_valid && rdy) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL win_unexpected: got r%0d c%0d, required no window", m_row, m_col);
            end else begin
                win_t e;
                e = sb.pop_front();
                if (m_row !== e.row || m_col !== e.col || m_pix !== e.pix) begin
                    fails++;
                    $display("FAIL win_data: got r%0d c%0d %h, required r%0d c%0d %h",
                             m_row, m_col, m_pix, e.row, e.col, e.pix);
                end
            end
        end
    end

    task automatic run_pass(input int hold_at, input int abort_at, output int acc);
        int          n, dcnt, hphase, hcnt, herr;
        bit          prev_hs, last_seen;
        logic [71:0] sp;
        logic [7:0]  sr, sc;
        acc = 0; dcnt = 0; hphase = 0; hcnt = 0; herr = 0; last_seen = 0;
        sp = '0; sr = '0; sc = '0;
        push_all();
        st = 1'b1; rdy = 1'b0;
        @(posedge clk); #1; st = 1'b0;
        chk("fetch_entry_rd_en", m_rd_en, 1);
        chk("fetch_entry_addr", m_rd_addr, 0);
        n = 0;
        while (!m_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("first_latency", n, sel ? 12 : 10);
        chk("first_pixels", m_pix, FIRST_PIX);
        chk("first_rowcol", {m_row, m_col}, 0);
        rdy = 1'b1;
        prev_hs = m_valid;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            @(posedge clk); #1; st = 1'b0;
            if (prev_hs) acc++;
            if (m_done) dcnt++;
            if (acc == abort_at && m_rd_en) begin
                reset_n = 1'b0; #1;
                chk("abort_outputs_zero",
                    {m_rd_en, m_rd_addr, m_valid, m_pix, m_row, m_col, m_busy, m_done}, 0);
                sb.delete();
                repeat (3) begin
                    @(posedge clk); #1;
                    if (m_done) dcnt++;
                end
                chk("abort_no_done", dcnt, 0);
                reset_n = 1'b1;
                return;
            end
            if (acc == 676) begin
                chk("done_after_last", {m_done, m_busy}, 2'b10);
                break;
            end
            if (acc == 50 && m_busy) st = 1'b1;
            if (acc == 675 && m_valid && !last_seen) begin
                last_seen = 1'b1;
                chk("last_pixels", m_pix, LAST_PIX);
                chk("last_rowcol", {m_row, m_col}, {8'd25, 8'd25});
            end
            if (hphase == 0 && acc == hold_at && m_valid) begin
                hphase = 1; sp = m_pix; sr = m_row; sc = m_col; rdy = 1'b0; hcnt = 0;
            end else if (hphase == 1) begin
                if (!m_valid || m_pix !== sp || m_row !== sr || m_col !== sc || m_rd_en) herr++;
                hcnt++;
                if (hcnt == 4) begin
                    rdy = 1'b1;
                    hphase = 2;
                end
            end else if (hphase == 2) begin
                chk("hold_stable", herr, 0);
                chk("fetch_after_hold", {m_rd_en, m_valid}, 2'b10);
                hphase = 3;
            end
            prev_hs = m_valid & rdy;
        end
        chk("accept_count", acc, 676);
        chk("done_count", dcnt, 1);
        st = 1'b1;
        @(posedge clk); #1; st = 1'b0;
        chk("done_one_cycle", {m_done, m_busy, m_rd_en}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("start_in_done_ignored", {m_busy, m_rd_en, m_valid}, 0);
        chk("sb_empty", sb.size(), 0);
        rdy = 1'b0;
    endtask

    initial begin
        int acc, rdbad;
        reset_n = 1'b0; st = 1'b0; rdy = 1'b0; sel = 1'b0; rdbad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            st = ~st;
            if (rd_en1 || rd_en3) rdbad++;
        end
        chk("reset_rd_en_never", rdbad, 0);
        chk("reset_outputs1", {rd_en1, rd_addr1, win_valid1, pix1, row1, col1, busy1, done1}, 0);
        chk("reset_outputs3", {rd_en3, rd_addr3, win_valid3, pix3, row3, col3, busy3, done3}, 0);
        st = 1'b0;
        @(posedge clk); #1; reset_n = 1'b1;
        @(posedge clk); #1;

        run_pass(3, 100, acc);
        chk("abort_at_window", acc, 100);
        @(posedge clk); #1;

        run_pass(3, -1, acc);
        @(posedge clk); #1;

        sel = 1'b1;
        run_pass(-1, -1, acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
